// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher between inst_rom and the fetch stage.
// Fetches consecutive words into a small FIFO of {pc, inst} pairs, hands
// them out with a ready/valid handshake, and flushes on redirect.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                rom_addr_o,
    output logic                       rom_ce_o,
    input  logic [31:0]                rom_data_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       inst_ready_i,
    output logic                       inst_valid_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                inst_pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [31:0]   fetch_pc;
    logic [63:0]   storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [63:0]   head;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    // Low address bits of the redirect target are forced to zero.
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Handshake decode; a full queue may still push when it pops the same cycle.
    always_comb begin
        pop  = inst_valid_o & inst_ready_i & ~redirect_i;
        push = rst & ~redirect_i & ((count < FULL) | pop);
    end

    assign rom_ce_o   = push;
    assign rom_addr_o = fetch_pc;

    // Head outputs come from registered state only, zeroed when empty.
    always_comb begin
        head         = storage[rd_ptr];
        inst_valid_o = (count != '0);
        inst_o       = inst_valid_o ? head[31:0]  : '0;
        inst_pc_o    = inst_valid_o ? head[63:32] : '0;
        count_o      = count;
    end

    // Fetch PC, pointers and occupancy; redirect flushes and restarts fetching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Entry storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push)
            storage[wr_ptr] <= {fetch_pc, rom_data_i};
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: table-driven streaming/redirect
// vectors plus hand sequences for fill/stall, async reset and PC wrap.
module tb_inst_prefetch_queue;

    logic        clk;
    logic        rst;

    logic [31:0] rom_addr1, rom_data1, redirect_pc1, inst1, inst_pc1;
    logic        rom_ce1, redirect1, ready1, valid1;
    logic [2:0]  count1;

    logic [31:0] rom_addr2, rom_data2, redirect_pc2, inst2, inst_pc2;
    logic        rom_ce2, redirect2, ready2, valid2;
    logic [2:0]  count2;

    int unsigned n_checks;
    int unsigned n_fail;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
        .clk(clk), .rst(rst),
        .rom_addr_o(rom_addr1), .rom_ce_o(rom_ce1), .rom_data_i(rom_data1),
        .redirect_i(redirect1), .redirect_pc_i(redirect_pc1),
        .inst_ready_i(ready1), .inst_valid_o(valid1),
        .inst_o(inst1), .inst_pc_o(inst_pc1), .count_o(count1)
    );

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .rom_addr_o(rom_addr2), .rom_ce_o(rom_ce2), .rom_data_i(rom_data2),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .inst_ready_i(ready2), .inst_valid_o(valid2),
        .inst_o(inst2), .inst_pc_o(inst_pc2), .count_o(count2)
    );

    // ROM contents: word i holds 32'h1000_0000 + i.
    assign rom_data1 = 32'h10000000 + {2'b00, rom_addr1[31:2]};
    assign rom_data2 = 32'h10000000 + {2'b00, rom_addr2[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  cnt;
        logic        ce;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst, input logic [2:0] cnt,
                             input logic ce, input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, valid1}, {31'd0, v});
        check({tag, ".pc"},    inst_pc1, pc);
        check({tag, ".inst"},  inst1, inst);
        check({tag, ".count"}, {29'd0, count1}, {29'd0, cnt});
        check({tag, ".ce"},    {31'd0, rom_ce1}, {31'd0, ce});
        check({tag, ".addr"},  rom_addr1, addr);
    endtask

    // Apply reset, then release it just after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        ready1 = 1'b0; redirect1 = 1'b0; redirect_pc1 = '0;
        ready2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;

        //           ready redir rpc           valid pc            inst          cnt ce addr
        vecs[0]  = '{1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 3'd0, 1'b1, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 32'h10000000, 3'd1, 1'b1, 32'h00000004};
        vecs[2]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000004, 32'h10000001, 3'd1, 1'b1, 32'h00000008};
        vecs[3]  = '{1'b1, 1'b1, 32'h00000043, 1'b1, 32'h00000008, 32'h10000002, 3'd1, 1'b0, 32'h0000000C};
        vecs[4]  = '{1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 3'd0, 1'b1, 32'h00000040};
        vecs[5]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000040, 32'h10000010, 3'd1, 1'b1, 32'h00000044};
        vecs[6]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000040, 32'h10000010, 3'd2, 1'b1, 32'h00000048};
        vecs[7]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000040, 32'h10000010, 3'd3, 1'b1, 32'h0000004C};
        vecs[8]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000040, 32'h10000010, 3'd4, 1'b0, 32'h00000050};
        vecs[9]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000040, 32'h10000010, 3'd4, 1'b0, 32'h00000050};
        vecs[10] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000040, 32'h10000010, 3'd4, 1'b1, 32'h00000050};
        vecs[11] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000044, 32'h10000011, 3'd4, 1'b0, 32'h00000054};
        vecs[12] = '{1'b1, 1'b1, 32'h00000100, 1'b1, 32'h00000044, 32'h10000011, 3'd4, 1'b0, 32'h00000054};
        vecs[13] = '{1'b1, 1'b1, 32'h00000204, 1'b0, 32'h00000000, 32'h00000000, 3'd0, 1'b0, 32'h00000100};
        vecs[14] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 3'd0, 1'b1, 32'h00000204};
        vecs[15] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000204, 32'h10000081, 3'd1, 1'b1, 32'h00000208};

        // Outputs while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        check("reset.wrap_addr", rom_addr2, 32'hFFFFFFF8);

        // Streaming, redirect, stall-to-full and redirect-with-ready.
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ready1       = vecs[i].ready;
            redirect1    = vecs[i].redir;
            redirect_pc1 = vecs[i].rpc;
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].inst,
                      vecs[i].cnt, vecs[i].ce, vecs[i].addr);
            step();
        end
        redirect1 = 1'b0;

        // Stall from release: fill to DEPTH, then one pop with concurrent push.
        do_reset();
        ready1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            check_all($sformatf("fill%0d", c), (c != 0), 32'h0,
                      (c != 0) ? 32'h10000000 : 32'h0, 3'(c), (c < 4),
                      32'(4 * c));
            step();
        end
        ready1 = 1'b1;
        #2;
        check_all("full_pop", 1'b1, 32'h0, 32'h10000000, 3'd4, 1'b1, 32'h10);
        step();
        ready1 = 1'b0;
        #2;
        check_all("after_pop", 1'b1, 32'h4, 32'h10000001, 3'd4, 1'b0, 32'h14);

        // Asynchronous reset between edges with three entries queued.
        do_reset();
        ready1 = 1'b0;
        repeat (3) step();
        #1;
        check("pre_areset.count", {29'd0, count1}, 32'd3);
        rst = 1'b0;
        #1;
        check_all("areset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
        step();
        rst = 1'b1;
        ready1 = 1'b1;
        #2;
        check_all("rel0", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0);
        step();
        #2;
        check_all("rel1", 1'b1, 32'h0, 32'h10000000, 3'd1, 1'b1, 32'h4);

        // PC wrap on the second instance: 3*DEPTH consecutive pops.
        do_reset();
        ready2 = 1'b1;
        #2;
        check("wrap0.valid", {31'd0, valid2}, 32'd0);
        check("wrap0.addr", rom_addr2, 32'hFFFFFFF8);
        step();
        for (int k = 0; k < 12; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'hFFFFFFF8 + 32'(4 * k);
            #2;
            check($sformatf("wrap%0d.valid", k + 1), {31'd0, valid2}, 32'd1);
            check($sformatf("wrap%0d.pc", k + 1), inst_pc2, exp_pc);
            check($sformatf("wrap%0d.inst", k + 1), inst2,
                  32'h10000000 + {2'b00, exp_pc[31:2]});
            check($sformatf("wrap%0d.count", k + 1), {29'd0, count2}, 32'd1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
